servant_wb_arb: RTL and testbench

SERVANT_WB_ARB -- requirements
Module: servant_wb_arb

---
 rtl/servant_wb_arb.sv | 145 ++++++++++++++
 tb/tb_servant_wb_arb.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/servant_wb_arb.sv
// Three-master Wishbone arbiter (ibus, dbus, debug) with round-robin grant
// and a bus timeout that completes a hung transfer with ERR_RDT.
module servant_wb_arb #(
   parameter int          TIMEOUT_W = 8,
   parameter logic [31:0] ERR_RDT   = 32'hDEADBEEF
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_ibus_adr,
   input  logic        i_ibus_cyc,
   output logic        o_ibus_ack,
   input  logic [31:0] i_dbus_adr,
   input  logic [31:0] i_dbus_dat,
   input  logic [3:0]  i_dbus_sel,
   input  logic        i_dbus_we,
   input  logic        i_dbus_cyc,
   output logic        o_dbus_ack,
   input  logic [31:0] i_dbg_adr,
   input  logic [31:0] i_dbg_dat,
   input  logic [3:0]  i_dbg_sel,
   input  logic        i_dbg_we,
   input  logic        i_dbg_cyc,
   output logic        o_dbg_ack,
   output logic [31:0] o_rdt,
   output logic [31:0] o_s_adr,
   output logic [31:0] o_s_dat,
   output logic [3:0]  o_s_sel,
   output logic        o_s_we,
   output logic        o_s_cyc,
   input  logic [31:0] i_s_rdt,
   input  logic        i_s_ack,
   output logic        o_timeout
);

   // state | meaning
   // IDLE  | no grant; picks the next requester starting at pointer p
   // BUSY  | master g owns the slave bus until ack, timeout or cyc drop
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   logic [0:0]           state;
   logic [1:0]           g;
   logic [1:0]           p;
   logic [TIMEOUT_W-1:0] t;

   logic [2:0] req;
   logic       busy;
   logic       cyc_g;
   logic [1:0] p1;
   logic [1:0] p2;
   logic [1:0] grant_nxt;
   logic       timeout;
   logic       ack_all;

   function automatic logic [1:0] inc3(input logic [1:0] x);
      return (x == 2'd2) ? 2'd0 : x + 2'd1;
   endfunction

   assign req  = {i_dbg_cyc, i_dbus_cyc, i_ibus_cyc};
   assign busy = (state == S_BUSY);
   assign p1   = inc3(p);
   assign p2   = inc3(p1);

   always_comb begin
      grant_nxt = p2;
      if (req[p])
         grant_nxt = p;
      else if (req[p1])
         grant_nxt = p1;
   end

   always_comb begin
      cyc_g   = 1'b0;
      o_s_adr = 32'h0;
      o_s_dat = 32'h0;
      o_s_sel = 4'h0;
      o_s_we  = 1'b0;
      case (g)
         2'd0: begin
            cyc_g   = i_ibus_cyc;
            o_s_adr = i_ibus_adr;
            o_s_sel = 4'hF;
         end
         2'd1: begin
            cyc_g   = i_dbus_cyc;
            o_s_adr = i_dbus_adr;
            o_s_dat = i_dbus_dat;
            o_s_sel = i_dbus_sel;
            o_s_we  = i_dbus_we;
         end
         2'd2: begin
            cyc_g   = i_dbg_cyc;
            o_s_adr = i_dbg_adr;
            o_s_dat = i_dbg_dat;
            o_s_sel = i_dbg_sel;
            o_s_we  = i_dbg_we;
         end
         default: ;
      endcase
   end

   // A real ack in the last allowed cycle takes precedence over the timeout.
   assign timeout    = busy & cyc_g & ~i_s_ack & (&t);
   assign ack_all    = busy & (i_s_ack | timeout);
   assign o_s_cyc    = busy & cyc_g;
   assign o_timeout  = timeout;
   assign o_rdt      = timeout ? ERR_RDT : i_s_rdt;
   assign o_ibus_ack = ack_all & (g == 2'd0);
   assign o_dbus_ack = ack_all & (g == 2'd1);
   assign o_dbg_ack  = ack_all & (g == 2'd2);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= S_IDLE;
         g     <= 2'd0;
         p     <= 2'd0;
         t     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (|req) begin
                  g     <= grant_nxt;
                  t     <= '0;
                  state <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (i_s_ack) begin
                  state <= S_IDLE;
                  p     <= inc3(g);
               end else if (!cyc_g) begin
                  state <= S_IDLE;
               end else if (&t) begin
                  state <= S_IDLE;
                  p     <= inc3(g);
               end else begin
                  t <= t + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_servant_wb_arb.sv
// Directed bench for servant_wb_arb with a 4-bit timeout counter.
module tb_servant_wb_arb;

   localparam logic [31:0] IADR = 32'h0000_0100;
   localparam logic [31:0] DADR = 32'h0000_0200;
   localparam logic [31:0] GADR = 32'h0000_0300;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [31:0] i_ibus_adr = IADR;
   logic        i_ibus_cyc = 1'b0;
   logic        o_ibus_ack;
   logic [31:0] i_dbus_adr = DADR;
   logic [31:0] i_dbus_dat = 32'h1111_2222;
   logic [3:0]  i_dbus_sel = 4'h3;
   logic        i_dbus_we = 1'b0;
   logic        i_dbus_cyc = 1'b0;
   logic        o_dbus_ack;
   logic [31:0] i_dbg_adr = GADR;
   logic [31:0] i_dbg_dat = 32'h3333_4444;
   logic [3:0]  i_dbg_sel = 4'hC;
   logic        i_dbg_we = 1'b1;
   logic        i_dbg_cyc = 1'b0;
   logic        o_dbg_ack;
   logic [31:0] o_rdt;
   logic [31:0] o_s_adr;
   logic [31:0] o_s_dat;
   logic [3:0]  o_s_sel;
   logic        o_s_we;
   logic        o_s_cyc;
   logic [31:0] i_s_rdt = 32'h0;
   logic        i_s_ack = 1'b0;
   logic        o_timeout;

   int checks = 0;
   int failures = 0;

   servant_wb_arb #(.TIMEOUT_W(4), .ERR_RDT(32'hDEADBEEF)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_ibus_adr(i_ibus_adr), .i_ibus_cyc(i_ibus_cyc), .o_ibus_ack(o_ibus_ack),
      .i_dbus_adr(i_dbus_adr), .i_dbus_dat(i_dbus_dat), .i_dbus_sel(i_dbus_sel),
      .i_dbus_we(i_dbus_we), .i_dbus_cyc(i_dbus_cyc), .o_dbus_ack(o_dbus_ack),
      .i_dbg_adr(i_dbg_adr), .i_dbg_dat(i_dbg_dat), .i_dbg_sel(i_dbg_sel),
      .i_dbg_we(i_dbg_we), .i_dbg_cyc(i_dbg_cyc), .o_dbg_ack(o_dbg_ack),
      .o_rdt(o_rdt), .o_s_adr(o_s_adr), .o_s_dat(o_s_dat), .o_s_sel(o_s_sel),
      .o_s_we(o_s_we), .o_s_cyc(o_s_cyc), .i_s_rdt(i_s_rdt), .i_s_ack(i_s_ack),
      .o_timeout(o_timeout)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic sample();
      @(negedge i_clk);
   endtask

   function automatic logic [31:0] acks();
      return {29'd0, o_dbg_ack, o_dbus_ack, o_ibus_ack};
   endfunction

   function automatic logic [31:0] adr_of(input int m);
      return (m == 0) ? IADR : (m == 1) ? DADR : GADR;
   endfunction

   initial begin
      int order[4];
      order = '{1, 2, 0, 1};

      // reset state
      step(); step();
      sample();
      chk("rst_s_cyc", {31'd0, o_s_cyc}, 32'd0);
      chk("rst_acks", acks(), 32'd0);
      chk("rst_timeout", {31'd0, o_timeout}, 32'd0);
      step();
      i_rst = 1'b0;

      // single ibus fetch, one-cycle grant latency
      step();
      i_ibus_cyc = 1'b1;
      sample();
      chk("ib_latency_cyc", {31'd0, o_s_cyc}, 32'd0);
      step();
      sample();
      chk("ib_busy_cyc", {31'd0, o_s_cyc}, 32'd1);
      chk("ib_adr", o_s_adr, IADR);
      chk("ib_sel", {28'd0, o_s_sel}, 32'hF);
      chk("ib_we", {31'd0, o_s_we}, 32'd0);
      chk("ib_dat", o_s_dat, 32'd0);
      chk("ib_noack_yet", acks(), 32'd0);
      step();
      i_s_ack = 1'b1;
      i_s_rdt = 32'h13;
      sample();
      chk("ib_ack", acks(), 32'd1);
      chk("ib_rdt", o_rdt, 32'h13);
      step();
      i_s_ack = 1'b0;
      i_ibus_cyc = 1'b0;
      sample();
      chk("ib_idle_after", {31'd0, o_s_cyc}, 32'd0);

      // all three request continuously: p=1 so dbus leads
      step();
      i_ibus_cyc = 1'b1;
      i_dbus_cyc = 1'b1;
      i_dbg_cyc  = 1'b1;
      sample();
      chk("rr_idle0", {31'd0, o_s_cyc}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         step();
         sample();
         chk("rr_grant_adr", o_s_adr, adr_of(order[k]));
         chk("rr_noack", acks(), 32'd0);
         step();
         i_s_ack = 1'b1;
         sample();
         chk("rr_ack", acks(), 32'd1 << order[k]);
         step();
         i_s_ack = 1'b0;
         sample();
         chk("rr_idle_gap", {31'd0, o_s_cyc}, 32'd0);
      end
      step();
      sample();
      chk("rr_next_dbg", o_s_adr, GADR);
      // granted master drops cyc: no ack, pointer stays on dbg
      i_ibus_cyc = 1'b0;
      i_dbus_cyc = 1'b0;
      i_dbg_cyc  = 1'b0;
      #1;
      chk("drop_s_cyc", {31'd0, o_s_cyc}, 32'd0);
      step();
      i_dbus_cyc = 1'b1;
      i_dbg_cyc  = 1'b1;
      sample();
      chk("drop_idle", acks(), 32'd0);
      step();
      sample();
      chk("drop_p_kept", o_s_adr, GADR);
      step();
      i_dbus_cyc = 1'b0;
      i_s_ack = 1'b1;
      sample();
      chk("dbg_ack", acks(), 32'd4);
      step();
      i_s_ack = 1'b0;
      i_dbg_cyc = 1'b0;

      // dbus write with ibus arriving mid-transfer
      i_dbus_adr = 32'h4000_0000;
      i_dbus_dat = 32'h1;
      i_dbus_sel = 4'h1;
      i_dbus_we  = 1'b1;
      i_dbus_cyc = 1'b1;
      sample();
      chk("wr_latency", {31'd0, o_s_cyc}, 32'd0);
      step();
      i_ibus_cyc = 1'b1;
      sample();
      chk("wr_adr", o_s_adr, 32'h4000_0000);
      chk("wr_dat", o_s_dat, 32'h1);
      chk("wr_sel", {28'd0, o_s_sel}, 32'h1);
      chk("wr_we", {31'd0, o_s_we}, 32'd1);
      chk("wr_holdoff", acks(), 32'd0);
      step();
      sample();
      chk("wr_holdoff2", acks(), 32'd0);
      step();
      i_s_ack = 1'b1;
      sample();
      chk("wr_ack", acks(), 32'd2);
      step();
      i_s_ack = 1'b0;
      i_dbus_cyc = 1'b0;
      i_dbus_we  = 1'b0;
      sample();
      chk("wr_idle", {31'd0, o_s_cyc}, 32'd0);
      step();
      sample();
      chk("held_ib_grant", o_s_adr, IADR);
      chk("held_ib_we", {31'd0, o_s_we}, 32'd0);
      step();
      i_s_ack = 1'b1;
      i_s_rdt = 32'h99;
      sample();
      chk("held_ib_ack", acks(), 32'd1);
      step();
      i_s_ack = 1'b0;
      i_ibus_cyc = 1'b0;

      // slave never acks: timeout in the 16th BUSY cycle
      i_dbus_cyc = 1'b1;
      i_s_rdt = 32'h77;
      step();
      for (int i = 0; i < 15; i++) begin
         sample();
         chk("to_wait", {30'd0, o_timeout, o_dbus_ack}, 32'd0);
         step();
      end
      sample();
      chk("to_ack", acks(), 32'd2);
      chk("to_flag", {31'd0, o_timeout}, 32'd1);
      chk("to_rdt", o_rdt, 32'hDEADBEEF);
      i_dbus_cyc = 1'b0;
      step();
      sample();
      chk("to_idle", {31'd0, o_s_cyc}, 32'd0);
      chk("to_flag_clr", {31'd0, o_timeout}, 32'd0);
      chk("to_rdt_clr", o_rdt, 32'h77);

      // ack lands in the last allowed cycle: ack wins over timeout
      step();
      i_dbus_cyc = 1'b1;
      step();
      for (int i = 0; i < 15; i++) step();
      i_s_ack = 1'b1;
      i_s_rdt = 32'h55;
      sample();
      chk("race_ack", acks(), 32'd2);
      chk("race_no_to", {31'd0, o_timeout}, 32'd0);
      chk("race_rdt", o_rdt, 32'h55);
      step();
      i_s_ack = 1'b0;
      i_dbus_cyc = 1'b0;

      // reset during a dbg transfer
      i_dbg_cyc = 1'b1;
      step();
      sample();
      chk("rst_dbg_busy", o_s_adr, GADR);
      i_ibus_cyc = 1'b1;
      i_dbus_cyc = 1'b1;
      i_rst = 1'b1;
      i_s_ack = 1'b1;
      step();
      sample();
      chk("midrst_s_cyc", {31'd0, o_s_cyc}, 32'd0);
      chk("midrst_acks", acks(), 32'd0);
      chk("midrst_to", {31'd0, o_timeout}, 32'd0);
      i_rst = 1'b0;
      i_s_ack = 1'b0;
      step();
      sample();
      chk("postrst_cyc", {31'd0, o_s_cyc}, 32'd1);
      chk("postrst_ibus_first", o_s_adr, IADR);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
